// File: rtl/io_channel_pkg.sv
// Shared definitions for the IO channel harness.
//   - DefaultWidth : default data word width of both channels
//   - state_e      : harness run state
//   - IN_TABLE     : words offered to the program on the in channel
//   - EXP_TABLE    : words the program is expected to emit on the out channel
//   - in_word/exp_word : bounds-safe table lookups (zero past the end)
package io_channel_pkg;

  localparam int unsigned DefaultWidth = 12;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone,
    StTimeout
  } state_e;

  localparam int unsigned InTableLen  = 3;
  localparam int unsigned ExpTableLen = 6;

  localparam int unsigned IN_TABLE  [InTableLen]  = '{33, 22, 11};
  localparam int unsigned EXP_TABLE [ExpTableLen] = '{3, 33, 2, 22, 1, 11};

  // Scan instead of indexing so an out-of-range position cannot read past the table.
  function automatic int unsigned in_word(int unsigned idx);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < InTableLen; i++) begin
      if (idx == i) w = IN_TABLE[i];
    end
    return w;
  endfunction

  function automatic int unsigned exp_word(int unsigned idx);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < ExpTableLen; i++) begin
      if (idx == i) w = EXP_TABLE[i];
    end
    return w;
  endfunction

endpackage

// File: rtl/io_channel_tx.sv
// In-channel transmitter: walks IN_TABLE one word per accepted transfer.
// Ports:
//   clock, reset          - clock, synchronous active-high reset
//   active                - harness is running; in_valid only asserts while high
//   in_ready              - program consumes in_data this cycle
//   in_valid, in_data     - current offered word
//   in_remaining          - words not yet consumed (N_IN - in_pos)
//   in_exhausted_next     - in_pos will equal N_IN after this cycle's transfer
module io_channel_tx
  import io_channel_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned N_IN  = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             active,
  input  logic             in_ready,
  output logic             in_valid,
  output logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] in_remaining,
  output logic             in_exhausted_next
);

  localparam logic [WIDTH-1:0] NIn = WIDTH'(N_IN);

  logic [WIDTH-1:0] in_pos_q, in_pos_d;
  logic             in_fire;

  // in_valid drops at N_IN, so in_pos saturates without a separate clamp.
  always_comb begin
    in_valid = active && (in_pos_q < NIn);
    in_fire  = in_valid && in_ready;
    in_pos_d = in_fire ? in_pos_q + WIDTH'(1) : in_pos_q;
  end

  assign in_data           = WIDTH'(in_word(32'(in_pos_q)));
  assign in_remaining      = NIn - in_pos_q;
  assign in_exhausted_next = (in_pos_d == NIn);

  always_ff @(posedge clock) begin
    if (reset) in_pos_q <= '0;
    else       in_pos_q <= in_pos_d;
  end

endmodule

// File: rtl/io_channel_harness.sv
// Test harness for a streaming program: feeds IN_TABLE on the in channel, checks the
// out channel against EXP_TABLE, and reports completion, pass/fail and the first bad word.
// Ports:
//   clock, reset                    - clock, synchronous active-high reset
//   in_valid, in_data, in_ready     - in channel (harness -> program)
//   in_remaining                    - words left on the in channel
//   out_valid, out_data, out_ready  - out channel (program -> harness)
//   finished, success               - run ended; success qualifies finished
//   mismatch_index                  - index of first failing out word, all-ones if none
module io_channel_harness
  import io_channel_pkg::*;
#(
  parameter int unsigned WIDTH   = DefaultWidth,
  parameter int unsigned N_IN    = 3,
  parameter int unsigned N_OUT   = 6,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clock,
  input  logic             reset,
  output logic             in_valid,
  output logic [WIDTH-1:0] in_data,
  input  logic             in_ready,
  output logic [WIDTH-1:0] in_remaining,
  input  logic             out_valid,
  input  logic [WIDTH-1:0] out_data,
  output logic             out_ready,
  output logic             finished,
  output logic             success,
  output logic [WIDTH-1:0] mismatch_index
);

  localparam int unsigned      CntW       = $clog2(TIMEOUT + 1);
  localparam logic [WIDTH-1:0] NOut       = WIDTH'(N_OUT);
  localparam logic [CntW-1:0]  TimeoutCnt = CntW'(TIMEOUT);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_pos_q, out_pos_d;
  logic [WIDTH-1:0] mismatch_q, mismatch_d;
  logic [CntW-1:0]  cycle_q, cycle_d;
  logic             error_q, error_d;
  logic             finished_q, finished_d;
  logic             success_q, success_d;
  logic             tx_active, in_exhausted_next;
  logic             out_fire, overflow, word_bad;

  io_channel_tx #(
    .WIDTH (WIDTH),
    .N_IN  (N_IN)
  ) u_tx (
    .clock             (clock),
    .reset             (reset),
    .active            (tx_active),
    .in_ready          (in_ready),
    .in_valid          (in_valid),
    .in_data           (in_data),
    .in_remaining      (in_remaining),
    .in_exhausted_next (in_exhausted_next)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next state: completion uses this cycle's post-transfer positions and wins over timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: state_d = StRun;
      StRun: begin
        if (in_exhausted_next && (out_pos_d == NOut)) state_d = StDone;
        else if (cycle_d == TimeoutCnt)               state_d = StTimeout;
      end
      StDone:    state_d = StDone;
      StTimeout: state_d = StTimeout;
      default:   state_d = StIdle;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    tx_active = (state_q == StRun);
    out_ready = (state_q == StRun) || (state_q == StDone);
  end

  // Out-channel checker and result bookkeeping.
  always_comb begin
    out_fire  = out_valid && out_ready;
    overflow  = out_fire && (out_pos_q >= NOut);
    word_bad  = out_fire && !overflow && (out_data != WIDTH'(exp_word(32'(out_pos_q))));
    out_pos_d = (out_fire && !overflow) ? out_pos_q + WIDTH'(1) : out_pos_q;
    error_d   = error_q || word_bad || overflow;

    mismatch_d = mismatch_q;
    if (mismatch_q == '1) begin
      if (word_bad)      mismatch_d = out_pos_q;
      else if (overflow) mismatch_d = NOut;
    end

    cycle_d = (state_q == StRun) ? cycle_q + CntW'(1) : cycle_q;

    finished_d = finished_q;
    success_d  = success_q;
    if (state_q == StRun && state_d == StDone) begin
      finished_d = 1'b1;
      success_d  = !error_d;
    end else if (state_q == StRun && state_d == StTimeout) begin
      finished_d = 1'b1;
      success_d  = 1'b0;
    end else if (state_q == StDone && error_d) begin
      // Extra words after completion still fail the run.
      success_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_pos_q  <= '0;
      mismatch_q <= '1;
      cycle_q    <= '0;
      error_q    <= 1'b0;
      finished_q <= 1'b0;
      success_q  <= 1'b0;
    end else begin
      out_pos_q  <= out_pos_d;
      mismatch_q <= mismatch_d;
      cycle_q    <= cycle_d;
      error_q    <= error_d;
      finished_q <= finished_d;
      success_q  <= success_d;
    end
  end

  assign finished       = finished_q;
  assign success        = success_q;
  assign mismatch_index = mismatch_q;

endmodule

// File: tb/tb_io_channel_harness.sv
// Bench for io_channel_harness: a program model consumes the in channel and emits
// (inSize, word) pairs; a reference model tracks expected positions and verdicts.
module tb_io_channel_harness;

  localparam int NIN  = 3;
  localparam int NOUT = 6;
  localparam logic [11:0] ONES = 12'hfff;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_ready = 1'b0;
  logic        out_valid = 1'b0;
  logic [11:0] out_data = '0;
  logic        in_valid, out_ready, finished, success;
  logic [11:0] in_data, in_remaining, mismatch_index;

  int checks   = 0;
  int failures = 0;
  int in_words [3] = '{33, 22, 11};

  io_channel_harness #(
    .WIDTH   (12),
    .N_IN    (NIN),
    .N_OUT   (NOUT),
    .TIMEOUT (64)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_ready       (in_ready),
    .in_remaining   (in_remaining),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_ready      (out_ready),
    .finished       (finished),
    .success        (success),
    .mismatch_index (mismatch_index)
  );

  always #5 clock = ~clock;

  // The program emits inSize then the word for each input, so word i of the out stream
  // is derived from input pair i/2.
  function automatic int exp_out(int i);
    return (i % 2 == 0) ? (NIN - i / 2) : in_words[i / 2];
  endfunction

  // One reset cycle with both channels active (must be ignored); ends at a negedge, released.
  task automatic pulse_reset();
    @(negedge clock);
    reset = 1'b1; in_ready = 1'b1; out_valid = 1'b1; out_data = 12'd3;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0; in_ready = 1'b0; out_valid = 1'b0;
  endtask

  // Runs the program model for `budget` cycles starting at the IDLE cycle after reset.
  task automatic run_program(input bit do_reset, input int ready_mode, input bit rand_out,
                             input int bad_idx, input int bad_val, input int out_limit,
                             input int extra_val, input bit check_fin, input int budget,
                             output int fin_cyc);
    int q[$];
    int m_in = 0, m_out = 0, sent = 0, pushed = 0, first_bad = -1, r, w;
    bit m_done = 0, m_err = 0, m_succ = 0, extra_done = 0, rdy, ifire, ofire;
    logic exp_v;
    logic [11:0] exp_mi;
    fin_cyc = -1;
    if (do_reset) pulse_reset();
    for (int k = 1; k <= budget; k++) begin
      checks++;
      if (in_remaining !== 12'(NIN - m_in)) begin
        failures++;
        $display("FAIL in_remaining cyc=%0d got=%0d exp=%0d", k, in_remaining, NIN - m_in);
      end
      exp_v = (k >= 2) && (m_in < NIN);
      checks++;
      if (in_valid !== exp_v) begin
        failures++;
        $display("FAIL in_valid cyc=%0d got=%b exp=%b", k, in_valid, exp_v);
      end
      if (exp_v) begin
        checks++;
        if (in_data !== 12'(in_words[m_in])) begin
          failures++;
          $display("FAIL in_data cyc=%0d got=%0d exp=%0d", k, in_data, in_words[m_in]);
        end
      end
      exp_mi = (first_bad < 0) ? ONES : 12'(first_bad);
      checks++;
      if (mismatch_index !== exp_mi) begin
        failures++;
        $display("FAIL mismatch_index cyc=%0d got=%0d exp=%0d", k, mismatch_index, exp_mi);
      end
      if (check_fin) begin
        checks++;
        if (finished !== m_done) begin
          failures++;
          $display("FAIL finished cyc=%0d got=%b exp=%b", k, finished, m_done);
        end
        checks++;
        if (success !== m_succ) begin
          failures++;
          $display("FAIL success cyc=%0d got=%b exp=%b", k, success, m_succ);
        end
        checks++;
        if (out_ready !== 1'(k >= 2)) begin
          failures++;
          $display("FAIL out_ready cyc=%0d got=%b exp=%b", k, out_ready, k >= 2);
        end
      end
      if (finished === 1'b1 && fin_cyc < 0) fin_cyc = k;

      // Drive this cycle's stimulus.
      case (ready_mode)
        0:       rdy = 1'b1;
        1:       rdy = !(k >= 3 && k <= 7);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      in_ready = rdy;
      if (m_done && extra_val >= 0 && !extra_done && q.size() == 0) begin
        q.push_back(extra_val);
        extra_done = 1'b1;
      end
      out_valid = (q.size() > 0) && (sent < out_limit) && (!rand_out || $urandom_range(0, 3) != 0);
      if (out_valid) out_data = 12'(q[0]);
      else           out_data = 12'($urandom_range(0, 4095));

      // Reference model of what the coming posedge does.
      ifire = (k >= 2) && (m_in < NIN) && rdy;
      ofire = out_valid && (k >= 2);
      if (ofire) begin
        void'(q.pop_front());
        sent++;
        if (m_out < NOUT) begin
          if (int'(out_data) != exp_out(m_out)) begin
            m_err = 1'b1;
            if (first_bad < 0) first_bad = m_out;
          end
          m_out++;
        end else begin
          m_err = 1'b1;
          if (first_bad < 0) first_bad = NOUT;
        end
      end
      if (ifire) begin
        r = NIN - m_in;
        w = in_words[m_in];
        if (pushed == bad_idx) r = bad_val;
        if (pushed + 1 == bad_idx) w = bad_val;
        q.push_back(r);
        q.push_back(w);
        pushed += 2;
        m_in++;
      end
      if (!m_done) begin
        if (m_in == NIN && m_out == NOUT) begin
          m_done = 1'b1;
          m_succ = !m_err;
        end
      end else if (ofire) begin
        m_succ = 1'b0;
      end
      @(posedge clock);
      @(negedge clock);
    end
    in_ready  = 1'b0;
    out_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1; in_ready = 1'b1; out_valid = 1'b1; out_data = 12'd3;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++; if (in_valid !== 1'b0) begin failures++; $display("FAIL rst_in_valid got=%b exp=0", in_valid); end
    checks++; if (out_ready !== 1'b0) begin failures++; $display("FAIL rst_out_ready got=%b exp=0", out_ready); end
    checks++; if (finished !== 1'b0) begin failures++; $display("FAIL rst_finished got=%b exp=0", finished); end
    checks++; if (success !== 1'b0) begin failures++; $display("FAIL rst_success got=%b exp=0", success); end
    checks++; if (mismatch_index !== ONES) begin failures++; $display("FAIL rst_mismatch got=%0d exp=%0d", mismatch_index, ONES); end
    checks++; if (in_remaining !== 12'd3) begin failures++; $display("FAIL rst_in_remaining got=%0d exp=3", in_remaining); end
    reset = 1'b0; in_ready = 1'b0; out_valid = 1'b0;
  endtask

  task automatic test_basic();
    int fc;
    run_program(1'b1, 0, 1'b0, -1, 0, 99, -1, 1'b1, 20, fc);
    checks++; if (fc < 0) begin failures++; $display("FAIL basic_finish got=none exp=within 20 cycles"); end
    checks++; if (success !== 1'b1) begin failures++; $display("FAIL basic_success got=%b exp=1", success); end
    checks++; if (mismatch_index !== ONES) begin failures++; $display("FAIL basic_mismatch got=%0d exp=%0d", mismatch_index, ONES); end
  endtask

  task automatic test_stall();
    int fc;
    run_program(1'b1, 1, 1'b0, -1, 0, 99, -1, 1'b1, 30, fc);
    checks++; if (finished !== 1'b1 || success !== 1'b1) begin
      failures++; $display("FAIL stall_result got=%b/%b exp=1/1", finished, success);
    end
  endtask

  task automatic test_mismatch();
    int fc;
    run_program(1'b1, 0, 1'b0, 3, 23, 99, -1, 1'b1, 20, fc);
    checks++; if (finished !== 1'b1) begin failures++; $display("FAIL mm_finished got=%b exp=1", finished); end
    checks++; if (success !== 1'b0) begin failures++; $display("FAIL mm_success got=%b exp=0", success); end
    checks++; if (mismatch_index !== 12'd3) begin failures++; $display("FAIL mm_index got=%0d exp=3", mismatch_index); end
  endtask

  task automatic test_overflow_after_done();
    int fc;
    run_program(1'b1, 0, 1'b0, -1, 0, 7, 5, 1'b1, 20, fc);
    checks++; if (finished !== 1'b1) begin failures++; $display("FAIL ovf_finished got=%b exp=1", finished); end
    checks++; if (success !== 1'b0) begin failures++; $display("FAIL ovf_success got=%b exp=0", success); end
    checks++; if (mismatch_index !== 12'd6) begin failures++; $display("FAIL ovf_index got=%0d exp=6", mismatch_index); end
  endtask

  task automatic test_timeout();
    int fc;
    run_program(1'b1, 0, 1'b0, -1, 0, 4, -1, 1'b0, 80, fc);
    // Cycle 1 is IDLE; 64 RUN cycles end at posedge 65, visible in cycle 66.
    checks++; if (fc < 64 || fc > 68) begin failures++; $display("FAIL to_cycle got=%0d exp=64..68", fc); end
    checks++; if (finished !== 1'b1) begin failures++; $display("FAIL to_finished got=%b exp=1", finished); end
    checks++; if (success !== 1'b0) begin failures++; $display("FAIL to_success got=%b exp=0", success); end
    checks++; if (out_ready !== 1'b0) begin failures++; $display("FAIL to_out_ready got=%b exp=0", out_ready); end
    checks++; if (mismatch_index !== ONES) begin failures++; $display("FAIL to_mismatch got=%0d exp=%0d", mismatch_index, ONES); end
  endtask

  task automatic test_reset_midrun();
    int fc;
    pulse_reset();
    in_ready = 1'b1; out_valid = 1'b0;
    repeat (3) begin @(posedge clock); @(negedge clock); end
    checks++; if (in_remaining !== 12'd1) begin failures++; $display("FAIL mid_pre_remaining got=%0d exp=1", in_remaining); end
    reset = 1'b1; out_valid = 1'b1; out_data = 12'd3;
    @(posedge clock);
    @(negedge clock);
    checks++; if (in_remaining !== 12'd3) begin failures++; $display("FAIL mid_remaining got=%0d exp=3", in_remaining); end
    checks++; if (in_data !== 12'd33) begin failures++; $display("FAIL mid_in_data got=%0d exp=33", in_data); end
    checks++; if (in_valid !== 1'b0) begin failures++; $display("FAIL mid_in_valid got=%b exp=0", in_valid); end
    reset = 1'b0; in_ready = 1'b0; out_valid = 1'b0;
    run_program(1'b0, 0, 1'b0, -1, 0, 99, -1, 1'b1, 20, fc);
    checks++; if (finished !== 1'b1 || success !== 1'b1) begin
      failures++; $display("FAIL mid_rerun got=%b/%b exp=1/1", finished, success);
    end
  endtask

  task automatic test_random();
    int fc, bi, bv;
    for (int it = 0; it < 6; it++) begin
      bi = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 5));
      bv = int'($urandom_range(0, 40));
      run_program(1'b1, 2, 1'b1, bi, bv, 99, -1, 1'b1, 60, fc);
      checks++; if (fc < 0) begin failures++; $display("FAIL rand_finish it=%0d got=none exp=finished", it); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_mismatch();
    test_overflow_after_done();
    test_timeout();
    test_reset_midrun();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
